wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the 64-bit pipeline. It takes the MEM/WB pipeline register outputs, selects the writeback value (memory data or ALU result), and commits it to a 32×64 register file. Two decode-stage read ports are provided, with same-cycle write-to-read bypass. It also exports the writeback value and a retired-write counter for the forwarding unit and for debug.

## Interface
Parameters:
- XLEN, 64, data width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- RegWrite_in  in  1  MEM/WB RegWrite_Out.
- MemtoReg_in  in  1  MEM/WB MemtoReg_Out; 1 selects memory data.
- DataOut_in  in  XLEN  MEM/WB DataOut (load data).
- AluOut_in  in  XLEN  MEM/WB AluOut.
- Rd_in  in  5  MEM/WB Rd_out (destination register).
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- wb_data  out  XLEN  selected writeback value (combinational).
- wb_en  out  1  qualified write enable (combinational).
- wb_rd  out  5  equal to Rd_in.
- wr_count  out  CNT_W  number of committed writes since reset.

## Operation
- wb_data = MemtoReg_in ? DataOut_in : AluOut_in.
- wb_en = RegWrite_in & (Rd_in != 0) & ~reset.
- On a rising edge with wb_en = 1: regs[Rd_in] <= wb_data, and wr_count increments by 1.
- Writes to x0 are discarded and do not count. The x0 read always returns 0, with no bypass.
- Read port n, for n = 1 or 2:
  - if rsn_addr == 0, the output is 0;
  - else if wb_en and rsn_addr == Rd_in, the output is wb_data (bypass);
  - otherwise the output is regs[rsn_addr].
- Both ports are independent. Both may bypass in the same cycle. Both may read the same register.
- MemtoReg_in is ignored when RegWrite_in = 0. No write occurs and no counter change occurs.
- wr_count wraps modulo 2^CNT_W (0xFFFF_FFFF + 1 -> 0). There is no saturation and no flag.

## Timing
- Reset asserted, asynchronously:
  - all regs clear to 0;
  - wr_count clears to 0;
  - wb_en = 0, so the bypass is disabled and rs1_data = rs2_data = 0.
  - wb_data still follows its inputs.
- A write presented in a cycle where reset is asserted at any point before the edge is dropped.
- Deassertion is sampled at the clock. The first write can commit at the first rising edge after reset falls.
- Write latency: 1 edge into the array. It is visible at the read ports in the same cycle through the bypass, so the read data seen by decode has effective latency 0.
- Reset mid-stream clears all architectural state. Nothing is retained or replayed.
- No handshake and no stall input. The block consumes one MEM/WB entry every cycle; bubbles arrive as RegWrite_in = 0.

## Structure
- Shared package riscv_pkg holds:
  - XLEN, NREGS, REG_ADDR_W = 5, CNT_W;
  - typedef xlen_t = logic [XLEN-1:0];
  - typedef reg_addr_t = logic [REG_ADDR_W-1:0].
- Sub-module regfile_array holds the storage:
  - 1 write port and 2 raw read ports;
  - asynchronous reset clear;
  - x0 write suppression.
- wb_regfile holds the writeback mux, the wb_en qualification, the bypass muxes and wr_count.

## Test plan
- Reset, then read all 32 registers on both ports -> every read is 0; wr_count = 0.
- RegWrite_in = 1, MemtoReg_in = 0, AluOut_in = 0x1122334455667788, Rd_in = 5; at the same time rs1_addr = 5 -> rs1_data = 0x1122334455667788 in the same cycle (bypass). After the edge, with RegWrite_in = 0, rs1_data still reads 0x1122334455667788; wr_count = 1.
- MemtoReg_in = 1, DataOut_in = 0xDEADBEEFCAFEF00D, AluOut_in = 0x1, Rd_in = 10, RegWrite_in = 1; rs1_addr = rs2_addr = 10 -> both outputs read 0xDEADBEEFCAFEF00D; wb_data matches.
- Write 0xFFFF_FFFF_FFFF_FFFF to Rd_in = 0 with RegWrite_in = 1 -> wb_en = 0; reading x0 gives 0; wr_count is unchanged.
- Fill x1..x31 with value = index, then assert reset asynchronously mid-cycle while a write to x7 is pending -> all outputs drop to 0 immediately; after release, x7 reads 0 and wr_count = 0.
- Force wr_count to 0xFFFF_FFFF (preload by hierarchical deposit), then perform one write -> wr_count = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths and types for the 64-bit integer pipeline.
package riscv_pkg;

   localparam int XLEN       = 64;
   localparam int NREGS      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 32;

   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/regfile_array.sv
// 32x64 integer register storage: one write port, two raw read ports.
// x0 is never written, so it always reads back as zero.
module regfile_array
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] raddr1,
   input  logic [REG_ADDR_W-1:0] raddr2,
   output logic [XLEN-1:0]       rdata1,
   output logic [XLEN-1:0]       rdata2
);

   xlen_t regs_q [NREGS];
   xlen_t regs_d [NREGS];

   // Next array contents: apply the write unless it targets x0.
   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   // Storage, cleared asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the
// register file, bypasses it to both decode read ports in the same cycle,
// and counts committed writes.
module wb_regfile
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWrite_in,
   input  logic                  MemtoReg_in,
   input  logic [XLEN-1:0]       DataOut_in,
   input  logic [XLEN-1:0]       AluOut_in,
   input  logic [REG_ADDR_W-1:0] Rd_in,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic [XLEN-1:0]       wb_data,
   output logic                  wb_en,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [CNT_W-1:0]      wr_count
);

   xlen_t raw1;
   xlen_t raw2;
   cnt_t  wr_count_q;
   cnt_t  wr_count_d;

   // Writeback select and write qualification; reset blocks the write and
   // therefore also the bypass, while wb_data keeps following its inputs.
   always_comb begin
      wb_data = MemtoReg_in ? DataOut_in : AluOut_in;
      wb_en   = RegWrite_in & (Rd_in != '0) & ~reset;
   end

   assign wb_rd = Rd_in;

   regfile_array u_array (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_en),
      .waddr  (Rd_in),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (raw1),
      .rdata2 (raw2)
   );

   // Read ports: x0 is hard zero, then same-cycle bypass, then the array.
   always_comb begin
      rs1_data = raw1;
      rs2_data = raw2;
      if (rs1_addr == '0) begin
         rs1_data = '0;
      end else if (wb_en && (rs1_addr == Rd_in)) begin
         rs1_data = wb_data;
      end
      if (rs2_addr == '0) begin
         rs2_data = '0;
      end else if (wb_en && (rs2_addr == Rd_in)) begin
         rs2_data = wb_data;
      end
   end

   // Retired-write count; wraps naturally at 2^CNT_W.
   always_comb begin
      wr_count_d = wr_count_q + (wb_en ? cnt_t'(1) : cnt_t'(0));
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
      end
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: array-based reference model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RegWrite_in = 1'b0;
   logic        MemtoReg_in = 1'b0;
   logic [63:0] DataOut_in = '0;
   logic [63:0] AluOut_in = '0;
   logic [4:0]  Rd_in = '0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic [63:0] wb_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wr_count;

   int errors = 0;
   int checks = 0;

   logic [63:0] m_regs [32];
   logic [31:0] m_cnt;

   wb_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .RegWrite_in (RegWrite_in),
      .MemtoReg_in (MemtoReg_in),
      .DataOut_in  (DataOut_in),
      .AluOut_in   (AluOut_in),
      .Rd_in       (Rd_in),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wb_data     (wb_data),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wr_count    (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_wbval();
      return MemtoReg_in ? DataOut_in : AluOut_in;
   endfunction

   function automatic logic m_wen();
      return RegWrite_in && (Rd_in != 5'd0) && !reset;
   endfunction

   function automatic logic [63:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (m_wen() && a == Rd_in) return m_wbval();
      return m_regs[a];
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
   end

   always @(posedge reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
   end

   always @(posedge clk) begin
      if (m_wen()) begin
         m_regs[Rd_in] = m_wbval();
         m_cnt = m_cnt + 32'd1;
      end
   end

   always @(negedge clk) begin
      chk("rs1_data", rs1_data, m_read(rs1_addr));
      chk("rs2_data", rs2_data, m_read(rs2_addr));
      chk("wb_data", wb_data, m_wbval());
      chk("wb_en", {63'd0, wb_en}, {63'd0, m_wen()});
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, Rd_in});
      chk("wr_count", {32'd0, wr_count}, {32'd0, m_cnt});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic m2r, input logic [63:0] dout,
                        input logic [63:0] alu, input logic [4:0] rd,
                        input logic [4:0] a1, input logic [4:0] a2);
      RegWrite_in = rw;
      MemtoReg_in = m2r;
      DataOut_in  = dout;
      AluOut_in   = alu;
      Rd_in       = rd;
      rs1_addr    = a1;
      rs2_addr    = a2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      step();

      // every register reads zero after reset
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, '0, '0, 5'd0, 5'(i), 5'(31 - i));
         #2;
         chk("post_reset_rs1", rs1_data, 64'd0);
         chk("post_reset_rs2", rs2_data, 64'd0);
         step();
      end
      chk("post_reset_cnt", {32'd0, wr_count}, 64'd0);

      // ALU writeback to x5 with same-cycle bypass
      drive(1'b1, 1'b0, '0, 64'h1122334455667788, 5'd5, 5'd5, 5'd0);
      #2 chk("bypass_x5", rs1_data, 64'h1122334455667788);
      step();
      RegWrite_in = 1'b0;
      #2 chk("stored_x5", rs1_data, 64'h1122334455667788);
      chk("cnt_after_x5", {32'd0, wr_count}, 64'd1);
      step();

      // load writeback to x10, both ports bypass
      drive(1'b1, 1'b1, 64'hDEADBEEFCAFEF00D, 64'h1, 5'd10, 5'd10, 5'd10);
      #2 chk("bypass_x10_p1", rs1_data, 64'hDEADBEEFCAFEF00D);
      chk("bypass_x10_p2", rs2_data, 64'hDEADBEEFCAFEF00D);
      chk("wb_data_load", wb_data, 64'hDEADBEEFCAFEF00D);
      step();
      RegWrite_in = 1'b0;
      #2 chk("stored_x10", rs2_data, 64'hDEADBEEFCAFEF00D);
      chk("cnt_after_x10", {32'd0, wr_count}, 64'd2);
      step();

      // MemtoReg ignored with RegWrite low
      drive(1'b0, 1'b1, 64'h5555, 64'h6666, 5'd5, 5'd5, 5'd10);
      #2 chk("nowrite_wben", {63'd0, wb_en}, 64'd0);
      chk("nowrite_rs1", rs1_data, 64'h1122334455667788);
      step();

      // write to x0 is discarded
      drive(1'b1, 1'b0, '0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
      #2 chk("x0_wben", {63'd0, wb_en}, 64'd0);
      chk("x0_rs1", rs1_data, 64'd0);
      step();
      RegWrite_in = 1'b0;
      #2 chk("x0_cnt", {32'd0, wr_count}, 64'd2);
      step();

      // fill x1..x31 with their index; port 1 reads previous, port 2 bypasses
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 1'b0, '0, 64'(i), 5'(i), 5'(i - 1), 5'(i));
         step();
      end
      drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd31, 5'd17);
      #2 chk("fill_x31", rs1_data, 64'd31);
      chk("fill_x17", rs2_data, 64'd17);
      chk("fill_cnt", {32'd0, wr_count}, 64'd33);
      step();

      // async reset mid-cycle while a write to x7 is pending
      drive(1'b1, 1'b0, '0, 64'h77, 5'd7, 5'd7, 5'd3);
      #1 chk("pre_rst_bypass", rs1_data, 64'h77);
      #1 reset = 1'b1;
      #1;
      chk("rst_rs1", rs1_data, 64'd0);
      chk("rst_rs2", rs2_data, 64'd0);
      chk("rst_wben", {63'd0, wb_en}, 64'd0);
      chk("rst_cnt", {32'd0, wr_count}, 64'd0);
      chk("rst_wbdata", wb_data, 64'h77);
      step();
      #1;
      RegWrite_in = 1'b0;
      reset = 1'b0;
      step();
      drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd7, 5'd31);
      #2 chk("after_rst_x7", rs1_data, 64'd0);
      chk("after_rst_x31", rs2_data, 64'd0);
      chk("after_rst_cnt", {32'd0, wr_count}, 64'd0);
      step();

      // counter wrap
      #1;
      dut.wr_count_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      drive(1'b1, 1'b0, '0, 64'hABCD, 5'd4, 5'd4, 5'd4);
      step();
      RegWrite_in = 1'b0;
      #2 chk("wrap_cnt", {32'd0, wr_count}, 64'd0);
      chk("wrap_x4", rs1_data, 64'hABCD);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
